// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory address/data, hazard/branch
// control from the pipeline, and the IF/ID register outputs.
// Optional performance counters are present when IF_PERF_CNT_EN is defined.
interface instruction_fetch_stage_if;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Freeze;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchAddr;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;
    logic        Halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    // Fetch stage side
    modport master (
        output Address,
        input  Instruction,
        input  Freeze,
        input  Flush,
        input  BranchTaken,
        input  BranchAddr,
        output IFID_PC,
        output IFID_Instruction,
        output IFID_Valid,
`ifdef IF_PERF_CNT_EN
        output FetchCount,
        output StallCount,
`endif
        output Halted
    );

    // Memory / pipeline environment side
    modport slave (
        input  Address,
        output Instruction,
        output Freeze,
        output Flush,
        output BranchTaken,
        output BranchAddr,
        input  IFID_PC,
        input  IFID_Instruction,
        input  IFID_Valid,
`ifdef IF_PERF_CNT_EN
        input  FetchCount,
        input  StallCount,
`endif
        input  Halted
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory, and loads the IF/ID register. Priority per edge is
// BranchTaken > Flush > Freeze > normal; fetch halts once PC reaches END_ADDR.
// Define IF_PERF_CNT_EN to add FetchCount/StallCount counters.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] END_ADDR = 32'h0000_001C,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic                      clk,
    input logic                      rst_n,
    instruction_fetch_stage_if.master bus
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_inc;
    logic [31:0] branch_pc;
    logic        fetch_load;
    logic [1:0]  unused_branch_lo;

    assign pc_inc           = pc_q + PC_STEP;
    assign branch_pc        = {bus.BranchAddr[31:2], 2'b00};
    assign unused_branch_lo = bus.BranchAddr[1:0];

    // Next-state selection for PC, IF/ID register and run/halt state
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        fetch_load   = 1'b0;
        if (bus.BranchTaken) begin
            pc_d         = branch_pc;
            ifid_pc_d    = '0;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
            state_d      = (branch_pc >= END_ADDR) ? HALT : RUN;
        end else if (bus.Flush) begin
            ifid_pc_d    = '0;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
            if (!bus.Freeze && state_q == RUN) begin
                pc_d = pc_inc;
                if (pc_inc == END_ADDR) state_d = HALT;
            end
        end else if (!bus.Freeze) begin
            if (state_q == RUN) begin
                ifid_instr_d = bus.Instruction;
                ifid_pc_d    = pc_inc;
                ifid_valid_d = 1'b1;
                fetch_load   = 1'b1;
                pc_d         = pc_inc;
                if (pc_inc == END_ADDR) state_d = HALT;
            end else begin
                // Memory data past the program is never captured
                ifid_instr_d = '0;
                ifid_valid_d = 1'b0;
            end
        end
        halted_d = (state_d == HALT);
    end

    // Pipeline and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.Address          = pc_q;
    assign bus.IFID_PC          = ifid_pc_q;
    assign bus.IFID_Instruction = ifid_instr_q;
    assign bus.IFID_Valid       = ifid_valid_q;
    assign bus.Halted           = halted_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments: valid loads and non-branch freeze cycles
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_load};
        stall_cnt_d = stall_cnt_q + {31'd0, bus.Freeze & ~bus.BranchTaken};
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.FetchCount = fetch_cnt_q;
    assign bus.StallCount = stall_cnt_q;
`else
    logic unused_fetch_load;
    assign unused_fetch_load = fetch_load;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares away from the clock edge.
module tb_instruction_fetch_stage;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic        chk_pc;
        logic [31:0] fc;
        logic [31:0] sc;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    instruction_fetch_stage_if bus();

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .END_ADDR (32'h0000_001C),
        .PC_STEP  (32'd4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [8];
    exp_t        sb[$];
    int          vectors;
    int          miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory; addresses past the program return a garbage
    // pattern standing in for an undriven bus.
    assign bus.Instruction = (bus.Address < 32'h1C) ? mem[bus.Address[4:2]] : 32'hBAD0_BAD0;

    task automatic push(input string nm, input logic [31:0] a, ip, ins,
                        input logic v, h, cp, input logic [31:0] fc, sc);
        exp_t e;
        e.name = nm; e.addr = a; e.ifpc = ip; e.instr = ins; e.valid = v;
        e.halted = h; e.chk_pc = cp; e.fc = fc; e.sc = sc;
        sb.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic fr, fl, bt, input logic [31:0] ba,
                       input logic [31:0] a, ip, ins, input logic v, h, cp,
                       input logic [31:0] fc, sc);
        bus.Freeze      = fr;
        bus.Flush       = fl;
        bus.BranchTaken = bt;
        bus.BranchAddr  = ba;
        @(posedge clk);
        #1;
        push(nm, a, ip, ins, v, h, cp, fc, sc);
    endtask

    // Monitor: compare one expectation per falling clock or reset assertion
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                ok = (bus.Address == e.addr) && (bus.IFID_Instruction == e.instr) &&
                     (bus.IFID_Valid == e.valid) && (bus.Halted == e.halted) &&
                     (!e.chk_pc || bus.IFID_PC == e.ifpc);
`ifdef IF_PERF_CNT_EN
                ok = ok && (bus.FetchCount == e.fc) && (bus.StallCount == e.sc);
`endif
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL %s: got addr=%h ifpc=%h instr=%h v=%0b h=%0b, expected addr=%h ifpc=%h(chk=%0b) instr=%h v=%0b h=%0b",
                             e.name, bus.Address, bus.IFID_PC, bus.IFID_Instruction, bus.IFID_Valid,
                             bus.Halted, e.addr, e.ifpc, e.chk_pc, e.instr, e.valid, e.halted);
`ifdef IF_PERF_CNT_EN
                    $display("  %s counters: got fc=%0d sc=%0d, expected fc=%0d sc=%0d",
                             e.name, bus.FetchCount, bus.StallCount, e.fc, e.sc);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d expected 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        mem[0] = 32'h0022_1000; mem[1] = 32'h0044_1004;
        mem[2] = 32'h0066_1008; mem[3] = 32'h0088_100C;
        mem[4] = 32'h00AA_1010; mem[5] = 32'h00CC_1014;
        mem[6] = 32'h00EE_1018; mem[7] = 32'h0100_101C;
        rst_n = 1'b0;
        bus.Freeze = 1'b0; bus.Flush = 1'b0; bus.BranchTaken = 1'b0; bus.BranchAddr = '0;
        @(posedge clk); #1;
        push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        //  name          fr  fl  bt  baddr        addr    ifpc    instr          v  h  cp fc sc
        cyc("run0",      0, 0, 0, 32'h0,  32'h04, 32'h04, 32'h0022_1000, 1, 0, 1, 1, 0);
        cyc("run1",      0, 0, 0, 32'h0,  32'h08, 32'h08, 32'h0044_1004, 1, 0, 1, 2, 0);
        cyc("run2",      0, 0, 0, 32'h0,  32'h0C, 32'h0C, 32'h0066_1008, 1, 0, 1, 3, 0);

        // Asynchronous reset between clock edges at PC=C
        @(negedge clk); #2;
        push("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        cyc("post_rst0", 0, 0, 0, 32'h0,  32'h04, 32'h04, 32'h0022_1000, 1, 0, 1, 1, 0);
        cyc("post_rst1", 0, 0, 0, 32'h0,  32'h08, 32'h08, 32'h0044_1004, 1, 0, 1, 2, 0);
        cyc("freeze0",   1, 0, 0, 32'h0,  32'h08, 32'h08, 32'h0044_1004, 1, 0, 1, 2, 1);
        cyc("freeze1",   1, 0, 0, 32'h0,  32'h08, 32'h08, 32'h0044_1004, 1, 0, 1, 2, 2);
        cyc("unfreeze",  0, 0, 0, 32'h0,  32'h0C, 32'h0C, 32'h0066_1008, 1, 0, 1, 3, 2);
        cyc("flush",     0, 1, 0, 32'h0,  32'h10, 32'h00, 32'h0,         0, 0, 1, 3, 2);
        cyc("br_frz",    1, 0, 1, 32'h06, 32'h04, 32'h00, 32'h0,         0, 0, 1, 3, 2);
        cyc("after_br",  0, 0, 0, 32'h0,  32'h08, 32'h08, 32'h0044_1004, 1, 0, 1, 4, 2);
        cyc("flush_frz", 1, 1, 0, 32'h0,  32'h08, 32'h00, 32'h0,         0, 0, 1, 4, 3);
        cyc("br_flush",  0, 1, 1, 32'h14, 32'h14, 32'h00, 32'h0,         0, 0, 1, 4, 3);
        cyc("run_14",    0, 0, 0, 32'h0,  32'h18, 32'h18, 32'h00CC_1014, 1, 0, 1, 5, 3);
        cyc("run_18",    0, 0, 0, 32'h0,  32'h1C, 32'h1C, 32'h00EE_1018, 1, 1, 1, 6, 3);
        cyc("halt0",     0, 0, 0, 32'h0,  32'h1C, 32'h00, 32'h0,         0, 1, 0, 6, 3);
        cyc("halt1",     0, 0, 0, 32'h0,  32'h1C, 32'h00, 32'h0,         0, 1, 0, 6, 3);
        cyc("halt_frz",  1, 0, 0, 32'h0,  32'h1C, 32'h00, 32'h0,         0, 1, 0, 6, 4);
        cyc("halt_br20", 0, 0, 1, 32'h20, 32'h20, 32'h00, 32'h0,         0, 1, 1, 6, 4);
        cyc("halt_at20", 0, 0, 0, 32'h0,  32'h20, 32'h00, 32'h0,         0, 1, 0, 6, 4);
        cyc("halt_br0",  0, 0, 1, 32'h0,  32'h00, 32'h00, 32'h0,         0, 0, 1, 6, 4);
        cyc("resume",    0, 0, 0, 32'h0,  32'h04, 32'h04, 32'h0022_1000, 1, 0, 1, 7, 4);
        cyc("br_mis1b",  0, 0, 1, 32'h1B, 32'h18, 32'h00, 32'h0,         0, 0, 1, 7, 4);
        cyc("run_last",  0, 0, 0, 32'h0,  32'h1C, 32'h1C, 32'h00EE_1018, 1, 1, 1, 8, 4);
        cyc("br_end",    0, 0, 1, 32'h1C, 32'h1C, 32'h00, 32'h0,         0, 1, 1, 8, 4);
        cyc("halt_ffl",  1, 1, 0, 32'h0,  32'h1C, 32'h00, 32'h0,         0, 1, 1, 8, 5);

        @(negedge clk); #3;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
